// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
// Oversampling UART receiver: 8 data bits, LSB first, optional parity, one stop bit.
// Feeds the receive FIFO directly (data_o / data_valid_o) and reports per-byte
// parity errors and framing errors.
//
// Ports
//   clk_i         system clock
//   reset_n_i     synchronous active-low reset
//   uart_rxd_i    asynchronous serial input, idles high
//   data_o        last received byte, held until the next valid byte
//   data_valid_o  one-cycle pulse, data_o valid
//   parity_err_o  parity mismatch on this byte, qualified by data_valid_o
//   frame_err_o   one-cycle pulse, stop bit sampled low
//   busy_o        receiver not idle
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line idle, waiting for rx low
// S_START  | counting to mid-start; rx high there rejects a glitch
// S_DATA   | sampling 8 data bits at bit centre, LSB first
// S_PARITY | sampling parity bit at bit centre
// S_STOP   | sampling stop bit at bit centre; emits byte or framing error
// S_BREAK  | line held low after a framing error, waiting for rx high

module uart_rx_oversample #(
    parameter int    ClkFreq        = 50000000,
    parameter int    BaudRate       = 115200,
    parameter int    OversampleRate = 16,
    parameter string ParityBit      = "none",
    parameter int    UseDebouncer   = 1
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       uart_rxd_i,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int DIV     = ClkFreq / (BaudRate * OversampleRate);
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OversampleRate);
    localparam bit PAR_EN  = (ParityBit != "none");
    localparam bit PAR_ODD = (ParityBit == "odd");

    localparam logic [SW-1:0] MID_START  = SW'(OversampleRate / 2 - 1);
    localparam logic [SW-1:0] BIT_CENTRE = SW'(OversampleRate - 1);

    generate
        if (DIV == 0) begin : g_div_check
            $error("uart_rx_oversample: ClkFreq too low for BaudRate*OversampleRate");
        end
        if ((OversampleRate < 4) || ((OversampleRate % 2) != 0)) begin : g_os_check
            $error("uart_rx_oversample: OversampleRate must be even and >= 4");
        end
        if ((ParityBit != "none") && (ParityBit != "even") && (ParityBit != "odd")) begin : g_par_check
            $error("uart_rx_oversample: ParityBit must be none, even or odd");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    sync_q, sync_d;
    logic [2:0]    filt_q, filt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          perr_q, perr_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          perr_out_q, perr_out_d;
    logic          ferr_q, ferr_d;

    logic tick;
    logic rx;
    logic maj;
    logic at_centre;

    assign tick      = (div_cnt_q == DW'(DIV - 1));
    assign maj       = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);
    assign rx        = (UseDebouncer != 0) ? maj : sync_q[1];
    assign at_centre = (scnt_q == BIT_CENTRE);

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        sync_d    = {sync_q[0], uart_rxd_i};
        filt_d    = tick ? {filt_q[1:0], sync_q[1]} : filt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            sync_q     <= 2'b11;
            filt_q     <= 3'b111;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            scnt_q     <= scnt_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_IDLE:   if (!rx) state_d = S_START;
                S_START:  if (scnt_q == MID_START) state_d = rx ? S_IDLE : S_DATA;
                S_DATA:   if (at_centre && (bcnt_q == 4'd7)) state_d = PAR_EN ? S_PARITY : S_STOP;
                S_PARITY: if (at_centre) state_d = S_STOP;
                S_STOP:   if (at_centre) state_d = rx ? S_IDLE : S_BREAK;
                S_BREAK:  if (rx) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Counters, shift register and the registered output pulses.
    always_comb begin
        scnt_d     = scnt_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = 1'b0;
        ferr_d     = 1'b0;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    scnt_d = '0;
                    bcnt_d = '0;
                    perr_d = 1'b0;
                end
                S_START: begin
                    scnt_d = (scnt_q == MID_START) ? '0 : scnt_q + 1'b1;
                end
                S_DATA: begin
                    if (at_centre) begin
                        scnt_d  = '0;
                        bcnt_d  = bcnt_q + 1'b1;
                        shreg_d = {rx, shreg_q[7:1]};
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (at_centre) begin
                        scnt_d = '0;
                        perr_d = ^shreg_q ^ rx ^ PAR_ODD;
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (at_centre) begin
                        scnt_d = '0;
                        if (rx) begin
                            valid_d    = 1'b1;
                            data_d     = shreg_q;
                            perr_out_d = PAR_EN & perr_q;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                default: begin
                    scnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy_o       = (state_q != S_IDLE);
        data_o       = data_q;
        data_valid_o = valid_q;
        parity_err_o = perr_out_q;
        frame_err_o  = ferr_q;
    end

endmodule
